// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and waits on mem_ready for the unified memory.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_NANDI = 6'b011000;

    state_t st, nxt;
    logic   op_bad;

    always_comb begin
        op_bad = 1'b0;
        nxt    = FETCH;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_NANDI:     nxt = IEXEC;
                    default: begin
                        nxt    = FETCH;
                        op_bad = 1'b1;
                    end
                endcase
            end
            MEMADR: nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:  nxt = FETCH;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            EXEC:   nxt = RCOMP;
            RCOMP:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            JUMP:   nxt = FETCH;
            IEXEC:  nxt = IWB;
            IWB:    nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else       st <= nxt;
    end

    assign state = st;

    // Outputs decode from state and are masked by reset so no strobe escapes
    // in the cycle reset is asserted, even from a pending memory wait.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    illegal = op_bad;
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop1  = 1'b1;
                end
                RCOMP: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BRANCH: begin
                    alusrca     = 1'b1;
                    aluop0      = 1'b1;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                IEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop1  = 1'b1;
                    aluop0  = 1'b1;
                end
                IWB: regwrite = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: instruction-level reference model (state sequence per
// opcode plus per-state output table) driven with randomized ops and memory latency.
module tb_multicycle_control;
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_NANDI = 6'b011000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic [3:0] state;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [16:0] obs;

    int checks   = 0;
    int failures = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .state(state),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                  regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for a state, in the same bit order as obs.
    function automatic logic [16:0] exp_out(input int s, input bit mr, input bit ill);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0, il = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00, aop = 2'b00;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            9:  begin pw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, pcs, aop, il};
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J || o == OP_NANDI;
    endfunction

    // Runs one instruction; cut >= 0 stops after that many cycles (DUT left mid-instruction).
    task automatic run_instr(input logic [5:0] iop, input int fw, input int mw, input int cut);
        int seq[$];
        bit ill = 0;
        int waits;
        int n = 0;
        case (iop)
            OP_LW:    seq = '{0, 1, 2, 3, 4};
            OP_SW:    seq = '{0, 1, 2, 5};
            OP_R:     seq = '{0, 1, 6, 7};
            OP_BEQ:   seq = '{0, 1, 8};
            OP_J:     seq = '{0, 1, 9};
            OP_NANDI: seq = '{0, 1, 10, 11};
            default: begin seq = '{0, 1}; ill = 1; end
        endcase
        foreach (seq[i]) begin
            waits = (seq[i] == 0) ? fw : ((seq[i] == 3 || seq[i] == 5) ? mw : 0);
            for (int w = 0; w <= waits; w++) begin
                if (cut >= 0 && n == cut) return;
                if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) mem_ready = (w == waits);
                else mem_ready = 1'($urandom_range(0, 1));
                op = (seq[i] == 1 || seq[i] == 2) ? iop : 6'($urandom);
                @(negedge clk);
                chk($sformatf("state_in_s%0d", seq[i]), 32'(state), 32'(seq[i]));
                chk($sformatf("outs_in_s%0d", seq[i]), 32'(obs), 32'(exp_out(seq[i], mem_ready, ill)));
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic do_reset(input int cycles, input int pre);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            op = 6'($urandom);
            @(negedge clk);
            if (i == 0 && pre >= 0) chk("state_before_reset", 32'(state), 32'(pre));
            if (i > 0) chk("state_in_reset", 32'(state), 0);
            chk("outs_in_reset", 32'(obs), 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 6))
            0: o = OP_R;
            1: o = OP_LW;
            2: o = OP_SW;
            3: o = OP_BEQ;
            4: o = OP_J;
            5: o = OP_NANDI;
            default: begin
                o = 6'($urandom);
                while (is_legal(o)) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        reset = 1'b1; op = '0; mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset(2, -1);

        run_instr(OP_LW, 0, 0, -1);
        run_instr(OP_SW, 0, 3, -1);
        run_instr(OP_R, 2, 0, -1);
        run_instr(OP_BEQ, 0, 0, -1);
        run_instr(OP_J, 1, 0, -1);
        run_instr(OP_NANDI, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);

        run_instr(OP_R, 0, 0, 3);      // parked in RCOMP
        do_reset(2, 7);
        run_instr(OP_LW, 0, 5, 5);     // parked in MEMRD waiting
        do_reset(2, 3);
        run_instr(OP_SW, 0, 5, 5);     // parked in MEMWR waiting
        do_reset(1, 5);

        for (int k = 0; k < 150; k++) begin
            logic [5:0] o = rand_op();
            int fw = $urandom_range(0, 3);
            int mw = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                run_instr(o, fw, mw, $urandom_range(1, 4));
                do_reset($urandom_range(1, 2), -1);
            end else begin
                run_instr(o, fw, mw, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multi-cycle variant of the MIPS-subset datapath. It sequences instruction fetch, decode, execute, memory and write-back over several cycles and drives the shared memory, register file, PC and ALU-source muxes. It issues the two-bit ALU operation class (`aluop1`/`aluop0`) that feeds the existing ALU-control decoder, which produces the 3-bit ALU function. It also waits on a memory-ready handshake so that a single unified memory can have variable latency.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  6  opcode field of the instruction register (`IR[31:26]`)
- `mem_ready`  in  1  memory completed the current read/write this cycle
- `state`  out  4  current state encoding, for debug/verification
- `pcwrite`, `pcwritecond`  out  1 each  unconditional PC write / PC write gated by datapath `zero`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memread`, `memwrite`  out  1 each  memory strobes
- `irwrite`  out  1  load instruction register
- `memtoreg`, `regdst`, `regwrite`  out  1 each  register write-back controls
- `alusrca`  out  1  0 = PC, 1 = register A
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pcsource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `aluop1`, `aluop0`  out  1 each  ALU class: 00 add, 01 subtract, 10 R-type (funct decoded downstream), 11 nandi
- `illegal`  out  1  one-cycle pulse on an undefined opcode

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12–15 go to FETCH on the next edge, with all outputs 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, nandi 011000.
- Moore outputs: each is a function of `state` alone, except the handshake-qualified strobes noted below. Any output not listed for a state is 0.
- FETCH:
  - `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, aluop=00, `pcsource`=00.
  - `irwrite`=`pcwrite`=`mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alusrca`=0, `alusrcb`=11, aluop=00 (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - nandi → IEXEC
  - otherwise → FETCH with `illegal`=1 for this cycle
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `memread`=1, `iord`=1. Hold until `mem_ready`=1, then go to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Next is FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Hold until `mem_ready`=1, then go to FETCH.
- EXEC: `alusrca`=1, `alusrcb`=00, aluop=10. Next is RCOMP.
- RCOMP: `regwrite`=1, `regdst`=1, `memtoreg`=0. Next is FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, aluop=01, `pcwritecond`=1, `pcsource`=01. Next is FETCH.
- JUMP: `pcwrite`=1, `pcsource`=10. Next is FETCH.
- IEXEC: `alusrca`=1, `alusrcb`=10, aluop=11. Next is IWB.
- IWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Next is FETCH.
- `op` is sampled only in DECODE and MEMADR. Changes to `op` in other states have no effect.

## Timing
- Reset:
  - `reset`=1 at a rising edge loads FETCH.
  - While `reset` is high, every output except `state` is forced to 0, including FETCH's `memread`.
  - First FETCH strobes appear in the first cycle after `reset` falls.
  - Reset overrides any state, including a pending MEMRD/MEMWR wait. No write strobe may be asserted in any cycle where `reset`=1.
- Cycle counts with `mem_ready` always 1:
  - lw: 5 cycles
  - sw, R-type, nandi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The state and all other outputs hold stable during the wait.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `irwrite` and `pcwrite` in FETCH are asserted only in the single completing cycle. Never two consecutive `pcwrite` cycles except FETCH followed by JUMP (impossible; DECODE intervenes).
- `memread` and `memwrite` are never both 1. `regwrite` is 1 only in MEMWB, RCOMP or IWB.

## Test plan
- Reset: hold `reset` 2 cycles from arbitrary state 7 → `state`=0 and all strobes 0 during reset. First post-reset cycle: `memread`=1, `alusrcb`=01.
- lw, `mem_ready`=1 → state sequence 0,1,2,3,4,0. `regwrite`=`memtoreg`=1 only in state 4. `iord`=1 in state 3.
- sw with `mem_ready` low for 3 cycles in MEMWR → state 5 for 4 cycles. `memwrite`=1 throughout. Exit to 0 on the cycle after `mem_ready`=1.
- FETCH with `mem_ready` low for 2 cycles → `irwrite`/`pcwrite` low for 2 cycles, then high for exactly 1 cycle. `state` goes to 1.
- R-type, beq, j, nandi:
  - R-type: states 0,1,6,7 with aluop=10 in state 6.
  - beq: states 0,1,8 with aluop=01, `pcwritecond`=1, `pcsource`=01.
  - j: state 9 with `pcsource`=10.
  - nandi: state 10 with aluop=11, then state 11 with `regdst`=0.
- op=111111 in DECODE → `illegal`=1 for one cycle, next state 0. Reset asserted while in MEMRD waiting → state 0, `memread`=0.
